// File: rtl/decode_stage_p_if.sv
// decode_stage_p_if
//   Bundles the signals between the IF/ID side, the write-back port and the
//   execute stage around decode_stage_p.
//
//   Upstream -> decode : instr_in, instr_valid, flush, wb_en, wb_addr, wb_data
//   Decode -> upstream : hazard_stall
//   Decode -> execute  : ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm,
//                        ex_rdst, ex_rsrc1, ex_rsrc2
//
//   Handshake: instr_valid marks instr_in as a real instruction. hazard_stall
//   is the decode stage's "not ready": while it is high the upstream side
//   must hold PC and IF/ID so the same instruction is offered again next
//   cycle. ex_valid marks the ID/EX contents as a real instruction;
//   ex_valid = 0 is a bubble and execute must ignore the control bits.
//
//   master modport: the driver of the decode stage (IF/ID + write-back).
//   slave modport : the decode stage itself.
interface decode_stage_p_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 3
);
    logic [INSTR_WIDTH-1:0]    instr_in;
    logic                      instr_valid;
    logic                      flush;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]     wb_data;

    logic                      hazard_stall;
    logic                      ex_valid;
    logic [7:0]                ex_ctrl;
    logic [DATA_WIDTH-1:0]     ex_rdata1;
    logic [DATA_WIDTH-1:0]     ex_rdata2;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [REG_ADDR_WIDTH-1:0] ex_rdst;
    logic [REG_ADDR_WIDTH-1:0] ex_rsrc1;
    logic [REG_ADDR_WIDTH-1:0] ex_rsrc2;

    modport master (
        output instr_in, instr_valid, flush, wb_en, wb_addr, wb_data,
        input  hazard_stall, ex_valid, ex_ctrl, ex_rdata1, ex_rdata2,
               ex_imm, ex_rdst, ex_rsrc1, ex_rsrc2
    );

    modport slave (
        input  instr_in, instr_valid, flush, wb_en, wb_addr, wb_data,
        output hazard_stall, ex_valid, ex_ctrl, ex_rdata1, ex_rdata2,
               ex_imm, ex_rdst, ex_rsrc1, ex_rsrc2
    );
endinterface

// File: rtl/decode_stage_p.sv
// decode_stage_p
//   Decode stage: register file with write-through bypass, control decode,
//   load-use hazard detection and the ID/EX pipeline register.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous reset, active low; clears ID/EX and register file
//     bus  - decode_stage_p_if.slave (instruction/write-back in, ID/EX out)
//
//   ex_ctrl layout: {alu_op[2:0], use_imm, mem_to_reg, mem_write, mem_read,
//                    reg_write}
module decode_stage_p #(
    parameter int DATA_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 3
) (
    input logic            clk,
    input logic            rst,
    decode_stage_p_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_USE_IMM    = 4;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [4:0]                opcode;
    logic [2:0]                rdst_f, rsrc1_f, rsrc2_f;
    logic [REG_ADDR_WIDTH-1:0] rdst, rsrc1, rsrc2;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      unused_ok;

    assign opcode  = bus.instr_in[15:11];
    assign rdst_f  = bus.instr_in[10:8];
    assign rsrc1_f = bus.instr_in[7:5];
    assign rsrc2_f = bus.instr_in[4:2];

    // Narrow register files keep the low bits of each 3-bit field.
    assign rdst  = REG_ADDR_WIDTH'(rdst_f);
    assign rsrc1 = REG_ADDR_WIDTH'(rsrc1_f);
    assign rsrc2 = REG_ADDR_WIDTH'(rsrc2_f);

    // Upper instruction half is the immediate, zero-extended or truncated.
    assign imm = DATA_WIDTH'(bus.instr_in[INSTR_WIDTH-1:16]);

    // instr[1:0] carry no meaning; fields may be partly dropped when narrow.
    assign unused_ok = ^{bus.instr_in[1:0], rdst_f, rsrc1_f, rsrc2_f};

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [7:0] ctrl;
    logic       is_real_op;

    assign is_real_op = bus.instr_valid && (opcode != 5'd0);

    always_comb begin
        ctrl = 8'h00;
        if (is_real_op) begin
            ctrl[7:5] = opcode[2:0];
            unique case (opcode[4:3])
                2'b00: begin
                    ctrl[CTRL_REG_WRITE] = 1'b1;
                end
                2'b01: begin
                    ctrl[CTRL_REG_WRITE] = 1'b1;
                    ctrl[CTRL_USE_IMM]   = 1'b1;
                end
                2'b10: begin
                    ctrl[CTRL_MEM_READ]   = 1'b1;
                    ctrl[CTRL_REG_WRITE]  = 1'b1;
                    ctrl[CTRL_MEM_TO_REG] = 1'b1;
                    ctrl[CTRL_USE_IMM]    = 1'b1;
                end
                default: begin
                    ctrl[CTRL_MEM_WRITE] = 1'b1;
                    ctrl[CTRL_USE_IMM]   = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file with write-through read bypass
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rdata1, rdata2;

    always_comb begin
        regs_d = regs_q;
        if (bus.wb_en) begin
            regs_d[bus.wb_addr] = bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A value being written back this cycle is seen by this cycle's decode.
    assign rdata1 = (bus.wb_en && (bus.wb_addr == rsrc1)) ? bus.wb_data : regs_q[rsrc1];
    assign rdata2 = (bus.wb_en && (bus.wb_addr == rsrc2)) ? bus.wb_data : regs_q[rsrc2];

    // ------------------------------------------------------------------
    // ID/EX register state
    // ------------------------------------------------------------------
    logic                      ex_valid_q,  ex_valid_d;
    logic [7:0]                ex_ctrl_q,   ex_ctrl_d;
    logic [DATA_WIDTH-1:0]     ex_rdata1_q, ex_rdata1_d;
    logic [DATA_WIDTH-1:0]     ex_rdata2_q, ex_rdata2_d;
    logic [DATA_WIDTH-1:0]     ex_imm_q,    ex_imm_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rdst_q,   ex_rdst_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rsrc1_q,  ex_rsrc1_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rsrc2_q,  ex_rsrc2_d;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX has not produced its data yet, so a
    // dependent instruction must wait one cycle. Only sources the opcode
    // actually reads are compared (rsrc2 is unused by immediate forms).
    // ------------------------------------------------------------------
    logic uses_rsrc1, uses_rsrc2, hazard_stall;

    assign uses_rsrc1 = is_real_op;
    assign uses_rsrc2 = is_real_op && !ctrl[CTRL_USE_IMM];

    assign hazard_stall = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] &&
                          ((uses_rsrc1 && (ex_rdst_q == rsrc1)) ||
                           (uses_rsrc2 && (ex_rdst_q == rsrc2)));

    // ------------------------------------------------------------------
    // ID/EX next state: flush or stall inserts a single all-zero bubble.
    // ------------------------------------------------------------------
    always_comb begin
        ex_valid_d  = bus.instr_valid;
        ex_ctrl_d   = ctrl;
        ex_rdata1_d = rdata1;
        ex_rdata2_d = rdata2;
        ex_imm_d    = imm;
        ex_rdst_d   = rdst;
        ex_rsrc1_d  = rsrc1;
        ex_rsrc2_d  = rsrc2;
        if (bus.flush || hazard_stall) begin
            ex_valid_d  = 1'b0;
            ex_ctrl_d   = 8'h00;
            ex_rdata1_d = '0;
            ex_rdata2_d = '0;
            ex_imm_d    = '0;
            ex_rdst_d   = '0;
            ex_rsrc1_d  = '0;
            ex_rsrc2_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= 8'h00;
            ex_rdata1_q <= '0;
            ex_rdata2_q <= '0;
            ex_imm_q    <= '0;
            ex_rdst_q   <= '0;
            ex_rsrc1_q  <= '0;
            ex_rsrc2_q  <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rdata1_q <= ex_rdata1_d;
            ex_rdata2_q <= ex_rdata2_d;
            ex_imm_q    <= ex_imm_d;
            ex_rdst_q   <= ex_rdst_d;
            ex_rsrc1_q  <= ex_rsrc1_d;
            ex_rsrc2_q  <= ex_rsrc2_d;
        end
    end

    assign bus.hazard_stall = hazard_stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_rdata1    = ex_rdata1_q;
    assign bus.ex_rdata2    = ex_rdata2_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rdst      = ex_rdst_q;
    assign bus.ex_rsrc1     = ex_rsrc1_q;
    assign bus.ex_rsrc2     = ex_rsrc2_q;

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;
    localparam int W = 66;  // {valid, ctrl, rdata1, rdata2, imm, rdst, rsrc1, rsrc2}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_stage_p_if #(.DATA_WIDTH(16), .INSTR_WIDTH(32), .REG_ADDR_WIDTH(3)) ifc0 ();
    decode_stage_p_if #(.DATA_WIDTH(32), .INSTR_WIDTH(32), .REG_ADDR_WIDTH(2)) ifc1 ();

    decode_stage_p #(.DATA_WIDTH(16), .INSTR_WIDTH(32), .REG_ADDR_WIDTH(3)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0)
    );

    decode_stage_p #(.DATA_WIDTH(32), .INSTR_WIDTH(32), .REG_ADDR_WIDTH(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           tests = 0;
    int           fails = 0;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {imm, op, rd, rs1, rs2, 2'b00};
    endfunction

    function automatic logic [W-1:0] got0();
        return {ifc0.ex_valid, ifc0.ex_ctrl, ifc0.ex_rdata1, ifc0.ex_rdata2,
                ifc0.ex_imm, ifc0.ex_rdst, ifc0.ex_rsrc1, ifc0.ex_rsrc2};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drives one decode cycle, checks the
    // combinational stall, queues the ID/EX contents expected after the edge.
    task automatic step(input int id, input logic [31:0] instr, input logic vld,
                        input logic fl, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic exp_stall,
                        input logic exp_v, input logic [7:0] exp_c,
                        input logic [15:0] e1, input logic [15:0] e2,
                        input logic [15:0] eimm, input logic [2:0] erd,
                        input logic [2:0] ers1, input logic [2:0] ers2);
        ifc0.instr_in    = instr;
        ifc0.instr_valid = vld;
        ifc0.flush       = fl;
        ifc0.wb_en       = we;
        ifc0.wb_addr     = wa;
        ifc0.wb_data     = wd;
        #1;
        chk($sformatf("hazard_stall step %0d", id), 128'(ifc0.hazard_stall), 128'(exp_stall));
        exp_q.push_back({exp_v, exp_c, e1, e2, eimm, erd, ers1, ers2});
        id_q.push_back(id);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [W-1:0] e;
                int           sid;
                e   = exp_q.pop_front();
                sid = id_q.pop_front();
                chk($sformatf("ex_bundle step %0d", sid), 128'(got0()), 128'(e));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        ifc0.instr_in = mk(5'd1, 3'd1, 3'd2, 3'd3, 16'h1234);
        ifc0.instr_valid = 1'b1;
        ifc0.flush = 1'b0;
        ifc0.wb_en = 1'b0;
        ifc0.wb_addr = '0;
        ifc0.wb_data = '0;
        ifc1.instr_in = 32'hABCD_4D20;
        ifc1.instr_valid = 1'b1;
        ifc1.flush = 1'b0;
        ifc1.wb_en = 1'b0;
        ifc1.wb_addr = '0;
        ifc1.wb_data = '0;

        // Reset held with a valid instruction present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold ex_bundle", 128'(got0()), 128'(0));
        chk("reset_hold stall", 128'(ifc0.hazard_stall), 128'(0));
        chk("reset_hold wide ex_valid", 128'(ifc1.ex_valid), 128'(0));
        rst = 1'b1;

        //   id instr                               v  fl we wa wd       stl v  ctrl   r1       r2       imm      rd rs1 rs2
        step(1,  mk(5'h01, 3'd4, 3'd3, 3'd0, 16'h0000), 1, 0, 1, 3, 16'h5555, 0, 1, 8'h21, 16'h5555, 16'h0000, 16'h0000, 4, 3, 0);
        step(2,  mk(5'h01, 3'd5, 3'd3, 3'd1, 16'h0000), 1, 0, 1, 1, 16'h00F0, 0, 1, 8'h21, 16'h5555, 16'h00F0, 16'h0000, 5, 3, 1);
        step(3,  mk(5'h12, 3'd2, 3'd1, 3'd0, 16'h0008), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h5B, 16'h00F0, 16'h0000, 16'h0008, 2, 1, 0);

        // Wider instance: immediate zero-extended, rdst = low two bits of 5.
        chk("wide ex_imm",   128'(ifc1.ex_imm),   128'(32'h0000ABCD));
        chk("wide ex_rdst",  128'(ifc1.ex_rdst),  128'(2'd1));
        chk("wide ex_ctrl",  128'(ifc1.ex_ctrl),  128'(8'h31));
        chk("wide ex_valid", 128'(ifc1.ex_valid), 128'(1));

        // Load-use on rsrc2: one stall + bubble, then the op with bypassed load data.
        step(4,  mk(5'h01, 3'd6, 3'd3, 3'd2, 16'h0000), 1, 0, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step(5,  mk(5'h01, 3'd6, 3'd3, 3'd2, 16'h0000), 1, 0, 1, 2, 16'h0BEE, 0, 1, 8'h21, 16'h5555, 16'h0BEE, 16'h0000, 6, 3, 2);
        // Immediate op uses R2 only as rsrc2 after a load to R2: no stall.
        step(6,  mk(5'h12, 3'd2, 3'd0, 3'd0, 16'h0000), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h5B, 16'h0000, 16'h0000, 16'h0000, 2, 0, 0);
        step(7,  mk(5'h09, 3'd7, 3'd3, 3'd2, 16'h0042), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h31, 16'h5555, 16'h0BEE, 16'h0042, 7, 3, 2);
        // Flush coincident with a load-use stall: exactly one bubble.
        step(8,  mk(5'h12, 3'd3, 3'd0, 3'd0, 16'h0000), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h5B, 16'h0000, 16'h0000, 16'h0000, 3, 0, 0);
        step(9,  mk(5'h09, 3'd1, 3'd3, 3'd0, 16'h0010), 1, 1, 0, 0, 16'h0000, 1, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step(10, mk(5'h09, 3'd1, 3'd3, 3'd0, 16'h0010), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h31, 16'h5555, 16'h0000, 16'h0010, 1, 3, 0);
        // Flush of a valid store.
        step(11, mk(5'h18, 3'd0, 3'd1, 3'd2, 16'h0004), 1, 1, 0, 0, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        // Immediate field extraction.
        step(12, 32'hABCD_4D20,                          1, 0, 0, 0, 16'h0000, 0, 1, 8'h31, 16'h00F0, 16'h0000, 16'hABCD, 5, 1, 0);
        step(13, mk(5'h18, 3'd0, 3'd1, 3'd2, 16'h0004), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h14, 16'h00F0, 16'h0BEE, 16'h0004, 0, 1, 2);
        // NOP after a load to R0: matching addresses but no stall.
        step(14, mk(5'h12, 3'd0, 3'd0, 3'd0, 16'h0000), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h5B, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step(15, 32'h0000_0000,                          1, 0, 0, 0, 16'h0000, 0, 1, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        // Invalid slot: ctrl forced to 0, data still decoded; R0 written.
        step(16, mk(5'h01, 3'd4, 3'd3, 3'd1, 16'h0000), 0, 0, 1, 0, 16'h7777, 0, 0, 8'h00, 16'h5555, 16'h00F0, 16'h0000, 4, 3, 1);
        step(17, mk(5'h01, 3'd1, 3'd0, 3'd0, 16'h0000), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h21, 16'h7777, 16'h7777, 16'h0000, 1, 0, 0);

        // Asynchronous reset mid-cycle clears ID/EX immediately.
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset ex_bundle", 128'(got0()), 128'(0));
        chk("async_reset wide ex_imm", 128'(ifc1.ex_imm), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        // Register file cleared: R0 and R2 read back zero.
        step(18, mk(5'h01, 3'd2, 3'd0, 3'd2, 16'h0000), 1, 0, 0, 0, 16'h0000, 0, 1, 8'h21, 16'h0000, 16'h0000, 16'h0000, 2, 0, 2);

        @(posedge clk);
        #2;
        chk("queue_drain", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
